// File: rtl/fifo_arb_pkg.sv
// Shared constants and width helpers for the round-robin FIFO arbiter.
package fifo_arb_pkg;

  localparam int R_DEF = 4;
  localparam int N_DEF = 4;
  localparam int M_DEF = 2;

  // Width needed to hold the values 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width needed to index n entries, never below one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_core.sv
// Circular word store with wrapping head/tail pointers and occupancy count.
module fifo_core
  import fifo_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic [M-1:0]        i_push_data,
  input  logic                i_ready,
  output logic [M-1:0]        o_data,
  output logic                o_valid,
  output logic                o_pop,
  output logic [cnt_w(N)-1:0] o_count,
  output logic                o_full
);

  localparam int CW = cnt_w(N);
  localparam int PW = idx_w(N);

  logic [M-1:0]  r_mem [N];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(N - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Outputs are forced to their idle values during reset so that a reset cycle is visibly empty
  assign w_valid = !reset && (r_count != {CW{1'b0}});
  assign w_push  = i_push && !reset;
  assign o_valid = w_valid;
  assign o_pop   = w_valid && i_ready;
  assign o_data  = w_valid ? r_mem[r_head] : {M{1'b0}};
  assign o_count = reset ? {CW{1'b0}} : r_count;
  assign o_full  = !reset && (r_count == CW'(N));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (o_pop) begin
        r_head <= ptr_inc(r_head);
      end
      case ({w_push, o_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter feeding a shared FIFO; define FIFO_ARB_PRIO0_EN to give
// requester 0 strict priority with rotation among the remaining requesters.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int R = R_DEF,
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [R-1:0]        req,
  input  logic [R*M-1:0]      data,
  output logic [R-1:0]        gnt,
  output logic [M-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [cnt_w(N)-1:0] count,
  output logic                full
);

  localparam int RW = idx_w(R);

  logic [RW-1:0] r_last;
  logic [RW-1:0] w_idx;
  logic          w_any;
  logic          w_pop;
  logic          w_full;
  logic          w_can_push;
  logic [M-1:0]  w_word;

  // A full queue still accepts a word when the head leaves in the same cycle
  assign w_can_push = !w_full || w_pop;

  always_comb begin
    int k;
    k     = 0;
    w_any = 1'b0;
    w_idx = r_last;
    if (!reset && w_can_push) begin
`ifdef FIFO_ARB_PRIO0_EN
      if (req[0]) begin
        w_any = 1'b1;
        w_idx = {RW{1'b0}};
      end else begin
        for (int i = 0; i < R - 1; i++) begin
          k = 1 + ((int'(r_last) + i) % (R - 1));
          if (!w_any && req[RW'(k)]) begin
            w_any = 1'b1;
            w_idx = RW'(k);
          end
        end
      end
`else
      for (int i = 0; i < R; i++) begin
        k = (int'(r_last) + 1 + i) % R;
        if (!w_any && req[RW'(k)]) begin
          w_any = 1'b1;
          w_idx = RW'(k);
        end
      end
`endif
    end else begin
      w_any = 1'b0;
    end
    gnt = w_any ? (R'(1) << w_idx) : {R{1'b0}};
  end

  always_comb begin
    w_word = {M{1'b0}};
    for (int j = 0; j < R; j++) begin
      if (w_idx == RW'(j)) begin
        w_word = data[j*M +: M];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= RW'(R - 1);
    end else if (w_any) begin
      r_last <= w_idx;
    end
  end

  fifo_core #(
    .N (N),
    .M (M)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_any),
    .i_push_data (w_word),
    .i_ready     (out_ready),
    .o_data      (out_data),
    .o_valid     (out_valid),
    .o_pop       (w_pop),
    .o_count     (count),
    .o_full      (w_full)
  );

  assign full = w_full;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Randomized and directed bench for fifo_arbiter against a queue-based reference model.
module tb_fifo_arbiter;

  localparam int R = 4;
  localparam int N = 4;
  localparam int M = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [R-1:0]   req;
  logic [R*M-1:0] data;
  logic [R-1:0]   gnt;
  logic [M-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     count;
  logic           full;

  int checks = 0;
  int errors = 0;
  int q[$];
  int last = R - 1;
  logic [R-1:0] seen;

  fifo_arbiter #(.R(R), .N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Winner under the rotation rule, or -1 when nothing may be granted
  function automatic int model_gnt(input logic [R-1:0] rq, input bit rst, input bit rdy);
    int k;
    if (rst) return -1;
    if (q.size() == N && !rdy) return -1;
`ifdef FIFO_ARB_PRIO0_EN
    if (rq[0]) return 0;
    for (int i = 1; i < R; i++) begin
      k = (last + i) % R;
      if (k != 0 && rq[k]) return k;
    end
    if (last != 0 && rq[last]) return last;
`else
    for (int i = 1; i <= R; i++) begin
      k = (last + i) % R;
      if (rq[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic step(input logic [R-1:0] rq, input logic [R*M-1:0] d,
                      input bit rdy, input bit rst, output int g);
    int head;
    @(negedge clk);
    req = rq; data = d; out_ready = rdy; reset = rst;
    #1;
    seen = gnt;
    g = model_gnt(rq, rst, rdy);
    head = (!rst && q.size() > 0) ? q[0] : 0;
    check("gnt", gnt, (g < 0) ? 0 : (1 << g));
    check("count", count, rst ? 0 : q.size());
    check("out_valid", out_valid, (!rst && q.size() > 0) ? 1 : 0);
    check("full", full, (!rst && q.size() == N) ? 1 : 0);
    check("out_data", out_data, head);
    @(posedge clk);
    if (rst) begin
      q.delete();
      last = R - 1;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back((d >> (g * M)) & ((1 << M) - 1));
        last = g;
      end
    end
  endtask

  initial begin
    int g;
    int exp_order [5];
    logic [R-1:0]   pend;
    logic [R*M-1:0] pdata;
    logic [R*M-1:0] d;
    bit rst;
    bit rdy;

    reset = 1'b1; req = '0; data = '0; out_ready = 1'b0;
    step(4'b0000, 8'h00, 1'b0, 1'b1, g);
    step(4'b1111, 8'hE4, 1'b1, 1'b1, g);
    check("reset_gnt", seen, 0);

    // Four requesters with words 0..3, consumer stalled
`ifdef FIFO_ARB_PRIO0_EN
    exp_order = '{1, 1, 1, 1, 0};
`else
    exp_order = '{1, 2, 4, 8, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 8'hE4, 1'b0, 1'b0, g);
      check("rr_order", seen, exp_order[i]);
    end
    #1;
    check("full_after4", full, 1);
    check("count_after4", count, 4);

    // Full queue drained while requester 0 refills
    for (int i = 0; i < 8; i++) begin
      d = '0;
      d[1:0] = 2'((i + 1) % 4);
      step(4'b0001, d, 1'b1, 1'b0, g);
      check("refill_gnt", seen, 1);
    end

    // Idle empty queue with consumer ready
    step(4'b0000, 8'h00, 1'b0, 1'b1, g);
    for (int i = 0; i < 3; i++) step(4'b0000, 8'hFF, 1'b1, 1'b0, g);

    // Wrap-around from requester 3 back to 0
    step(4'b1000, 8'hC0, 1'b1, 1'b0, g);
    check("wrap_g3", seen, 8);
    step(4'b1001, 8'hC3, 1'b1, 1'b0, g);
    check("wrap_g0", seen, 1);
    step(4'b1000, 8'hC0, 1'b1, 1'b0, g);
    check("wrap_g3b", seen, 8);

    // Reset mid-operation with three words stored
    step(4'b0000, 8'h00, 1'b0, 1'b1, g);
    for (int i = 0; i < 3; i++) step(4'b0001, 8'h02, 1'b0, 1'b0, g);
    #1;
    check("count3", count, 3);
    step(4'b1111, 8'hE4, 1'b0, 1'b1, g);
    step(4'b1111, 8'hE4, 1'b0, 1'b0, g);
    check("post_reset_gnt", seen, 1);

`ifdef FIFO_ARB_PRIO0_EN
    step(4'b0000, 8'h00, 1'b0, 1'b1, g);
    for (int i = 0; i < 6; i++) begin
      step(4'b0111, 8'h1B, 1'b0, 1'b0, g);
      check("prio0_gnt", seen, (i < 4) ? 1 : 0);
    end
`endif

    // Random traffic: requesters hold req and data until granted
    step(4'b0000, 8'h00, 1'b0, 1'b1, g);
    pend = '0;
    pdata = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < R; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          pdata[k*M +: M] = M'($urandom);
        end
      end
      rst = ($urandom_range(0, 49) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      step(pend, pdata, rdy, rst, g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
